// File: rtl/miner_nonce_sequencer.sv
// Interleaved nonce sequencer: core i walks base+i, base+i+CORES, ... up to limit (inclusive).
// Optional MINER_SEQ_PAUSE_EN adds a pause input that freezes a run without aborting it.
module miner_nonce_sequencer #(
  parameter int CORES = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
`ifdef MINER_SEQ_PAUSE_EN
  input  logic                   pause,
`endif
  input  logic [WIDTH-1:0]       base_nonce,
  input  logic [WIDTH-1:0]       limit_nonce,
  input  logic [CORES-1:0]       advance,
  output logic [CORES*WIDTH-1:0] nonce_out,
  output logic [CORES-1:0]       nonce_valid,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       consumed_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH:0] STEP = (WIDTH+1)'(CORES);

  state_t                 r_state, w_state_nxt;
  logic [CORES*WIDTH-1:0] r_nonce, w_nonce_nxt;
  logic [CORES-1:0]       r_valid, w_valid_nxt, w_accept;
  logic [WIDTH-1:0]       r_limit, w_limit_nxt;
  logic [WIDTH-1:0]       r_count, w_count_nxt;
  logic                   r_busy, r_done;
  logic                   w_pause;
  logic [WIDTH:0]         w_start_sum [CORES];
  logic [WIDTH:0]         w_step_sum  [CORES];

`ifdef MINER_SEQ_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  function automatic logic [4:0] popcount(input logic [CORES-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int k = 0; k < CORES; k++) c = c + {4'd0, v[k]};
    return c;
  endfunction

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a, input logic [4:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + (WIDTH+1)'(b);
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  // One extra bit on every sum so a carry out of the nonce space reads as "past limit".
  for (genvar g = 0; g < CORES; g++) begin : g_lane
    assign w_start_sum[g] = {1'b0, base_nonce} + (WIDTH+1)'(g);
    assign w_step_sum[g]  = {1'b0, r_nonce[g*WIDTH +: WIDTH]} + STEP;
  end

  assign w_accept = advance & r_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_nonce_nxt = r_nonce;
    w_valid_nxt = r_valid;
    w_limit_nxt = r_limit;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_RUN;
          w_limit_nxt = limit_nonce;
          w_count_nxt = '0;
          for (int i = 0; i < CORES; i++) begin
            w_valid_nxt[i] = (w_start_sum[i] <= {1'b0, limit_nonce});
            w_nonce_nxt[i*WIDTH +: WIDTH] = w_start_sum[i][WIDTH] ? {WIDTH{1'b1}}
                                                                   : w_start_sum[i][WIDTH-1:0];
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = '0;
        end else if (!w_pause) begin
          if (r_valid == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_count_nxt = sat_add(r_count, popcount(w_accept));
            for (int i = 0; i < CORES; i++) begin
              if (w_accept[i]) begin
                w_valid_nxt[i] = (w_step_sum[i] <= {1'b0, r_limit});
                // On overflow the old nonce is kept; the lane is already invalid.
                if (!w_step_sum[i][WIDTH]) w_nonce_nxt[i*WIDTH +: WIDTH] = w_step_sum[i][WIDTH-1:0];
              end
            end
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_nonce <= '0;
      r_valid <= '0;
      r_limit <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_nonce <= w_nonce_nxt;
      r_valid <= w_valid_nxt;
      r_limit <= w_limit_nxt;
      r_count <= w_count_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign nonce_out      = r_nonce;
  assign nonce_valid    = r_valid;
  assign busy           = r_busy;
  assign done           = r_done;
  assign consumed_count = r_count;

endmodule

// File: tb/tb_miner_nonce_sequencer.sv
// Self-checking bench for miner_nonce_sequencer (CORES=4, WIDTH=32) against a behavioural model.
module tb_miner_nonce_sequencer;

  localparam int CORES = 4;
  localparam int WIDTH = 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic                   pause = 1'b0;
  logic [WIDTH-1:0]       base_nonce = '0;
  logic [WIDTH-1:0]       limit_nonce = '0;
  logic [CORES-1:0]       advance = '0;
  logic [CORES*WIDTH-1:0] nonce_out;
  logic [CORES-1:0]       nonce_valid;
  logic                   busy;
  logic                   done;
  logic [WIDTH-1:0]       consumed_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each lane is just "current nonce as an unbounded integer"; valid means nonce <= limit.
  longint m_nonce [CORES];
  bit     m_val   [CORES];
  longint m_limit;
  longint m_count;
  bit     m_run;
  bit     m_done;

  miner_nonce_sequencer #(.CORES(CORES), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
`ifdef MINER_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .base_nonce(base_nonce),
    .limit_nonce(limit_nonce),
    .advance(advance),
    .nonce_out(nonce_out),
    .nonce_valid(nonce_valid),
    .busy(busy),
    .done(done),
    .consumed_count(consumed_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < CORES; i++) begin m_nonce[i] = 0; m_val[i] = 0; end
    m_limit = 0; m_count = 0; m_run = 0; m_done = 0;
  endtask

  task automatic model_clock(input bit st, input bit ab, input bit pz, input logic [CORES-1:0] adv,
                             input longint b, input longint l);
    bit any;
    if (m_done) begin
      m_done = 0;
    end else if (!m_run) begin
      if (st && !ab) begin
        m_run = 1; m_limit = l; m_count = 0;
        for (int i = 0; i < CORES; i++) begin
          m_nonce[i] = b + i;
          m_val[i]   = (m_nonce[i] <= m_limit);
        end
      end
    end else if (ab) begin
      m_run = 0;
      for (int i = 0; i < CORES; i++) m_val[i] = 0;
    end else if (!pz) begin
      any = 0;
      for (int i = 0; i < CORES; i++) any |= m_val[i];
      if (!any) begin
        m_run = 0; m_done = 1;
      end else begin
        for (int i = 0; i < CORES; i++) begin
          if (adv[i] && m_val[i]) begin
            if (m_count < 64'hFFFF_FFFF) m_count++;
            m_nonce[i] += CORES;
            m_val[i] = (m_nonce[i] <= m_limit);
          end
        end
      end
    end
  endtask

  // Observed and expected summaries; nonce slices are only meaningful while the model says valid.
  function automatic logic [165:0] obs_vec();
    logic [127:0] n;
    n = '0;
    for (int i = 0; i < CORES; i++) if (m_val[i]) n[i*32 +: 32] = nonce_out[i*32 +: 32];
    return {busy, done, nonce_valid, consumed_count, n};
  endfunction

  function automatic logic [165:0] exp_vec();
    logic [127:0] n;
    logic [3:0]   v;
    logic [63:0]  t;
    n = '0;
    for (int i = 0; i < CORES; i++) begin
      v[i] = m_val[i];
      t = m_nonce[i];
      if (m_val[i]) n[i*32 +: 32] = t[31:0];
    end
    t = m_count;
    return {m_run, m_done, v, t[31:0], n};
  endfunction

  // One clock: apply inputs, let the edge happen, advance the model, settle 1 ns past the edge.
  task automatic cyc(input bit st, input bit ab, input bit pz, input logic [CORES-1:0] adv,
                     input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] l);
    bit pz_eff;
    start = st; abort = ab; advance = adv; base_nonce = b; limit_nonce = l;
`ifdef MINER_SEQ_PAUSE_EN
    pause = pz; pz_eff = pz;
`else
    pause = 1'b0; pz_eff = 1'b0;
`endif
    @(posedge clk);
    model_clock(st, ab, pz_eff, adv, longint'(b), longint'(l));
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, nonce_valid, consumed_count, nonce_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got %h want 0", {busy, done, nonce_valid, consumed_count, nonce_out});
    end
    rst = 1'b0;
    cyc(0, 0, 0, 4'b0000, '0, '0);
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_idle got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single_core();
    cyc(1, 0, 0, 4'b0000, 32'd0, 32'd15);
    n_cmp++;
    if ({busy, nonce_valid, nonce_out} !== {1'b1, 4'b1111, 128'h00000003_00000002_00000001_00000000}) begin
      n_bad++; $display("FAIL start_load got %h want %h", {busy, nonce_valid, nonce_out},
                        {1'b1, 4'b1111, 128'h00000003_00000002_00000001_00000000});
    end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 4'b0001, '0, '0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL core0_step%0d got %h want %h", k, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({nonce_valid, consumed_count, nonce_out[127:32]} !== {4'b1110, 32'd4, 96'h00000003_00000002_00000001}) begin
      n_bad++; $display("FAIL core0_exhaust got %h want %h", {nonce_valid, consumed_count, nonce_out[127:32]},
                        {4'b1110, 32'd4, 96'h00000003_00000002_00000001});
    end
    cyc(0, 1, 0, 4'b0000, '0, '0);
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL core0_abort got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_all_cores();
    cyc(1, 0, 0, 4'b0000, 32'd0, 32'd15);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 4'b1111, '0, '0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL all_step%0d got %h want %h", k, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({busy, done, nonce_valid} !== {1'b1, 1'b0, 4'b0000}) begin
      n_bad++; $display("FAIL all_drained got %b want 1_0_0000", {busy, done, nonce_valid});
    end
    cyc(0, 0, 0, 4'b1111, '0, '0);
    n_cmp++;
    if ({busy, done, consumed_count} !== {1'b0, 1'b1, 32'd16}) begin
      n_bad++; $display("FAIL all_done got %h want %h", {busy, done, consumed_count}, {1'b0, 1'b1, 32'd16});
    end
    cyc(0, 0, 0, 4'b0000, '0, '0);
    n_cmp++;
    if ({busy, done, consumed_count} !== {1'b0, 1'b0, 32'd16}) begin
      n_bad++; $display("FAIL all_done_pulse got %h want %h", {busy, done, consumed_count}, {1'b0, 1'b0, 32'd16});
    end
  endtask

  task automatic test_top_of_range();
    cyc(1, 0, 0, 4'b0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    n_cmp++;
    if ({nonce_valid, nonce_out[63:0]} !== {4'b0011, 64'hFFFFFFFF_FFFFFFFE}) begin
      n_bad++; $display("FAIL top_load got %h want %h", {nonce_valid, nonce_out[63:0]}, {4'b0011, 64'hFFFFFFFF_FFFFFFFE});
    end
    cyc(0, 0, 0, 4'b1111, '0, '0);
    n_cmp++;
    if ({busy, nonce_valid, consumed_count} !== {1'b1, 4'b0000, 32'd2}) begin
      n_bad++; $display("FAIL top_nowrap got %h want %h", {busy, nonce_valid, consumed_count}, {1'b1, 4'b0000, 32'd2});
    end
    cyc(0, 0, 0, 4'b1111, '0, '0);
    n_cmp++;
    if ({busy, done, consumed_count} !== {1'b0, 1'b1, 32'd2}) begin
      n_bad++; $display("FAIL top_done got %h want %h", {busy, done, consumed_count}, {1'b0, 1'b1, 32'd2});
    end
    cyc(0, 0, 0, 4'b0000, '0, '0);
  endtask

  task automatic test_abort_and_empty();
    cyc(1, 0, 0, 4'b0000, 32'd100, 32'd200);
    cyc(0, 0, 0, 4'b1111, '0, '0);
    cyc(1, 0, 0, 4'b0101, 32'd5, 32'd6);
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL start_in_run got %h want %h", obs_vec(), exp_vec());
    end
    cyc(0, 1, 0, 4'b1111, '0, '0);
    n_cmp++;
    if ({busy, done, nonce_valid, consumed_count} !== {1'b0, 1'b0, 4'b0000, 32'd6}) begin
      n_bad++; $display("FAIL abort_run got %h want %h", {busy, done, nonce_valid, consumed_count}, {1'b0, 1'b0, 4'b0000, 32'd6});
    end
    cyc(0, 0, 0, 4'b0000, '0, '0);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL abort_no_done got %b want 00", {busy, done});
    end
    cyc(1, 1, 0, 4'b0000, 32'd0, 32'd15);
    n_cmp++;
    if ({busy, nonce_valid, consumed_count} !== {1'b0, 4'b0000, 32'd6}) begin
      n_bad++; $display("FAIL start_abort_same got %h want %h", {busy, nonce_valid, consumed_count}, {1'b0, 4'b0000, 32'd6});
    end
    cyc(1, 0, 0, 4'b0000, 32'd20, 32'd10);
    n_cmp++;
    if ({busy, done, nonce_valid, consumed_count} !== {1'b1, 1'b0, 4'b0000, 32'd0}) begin
      n_bad++; $display("FAIL empty_run got %h want %h", {busy, done, nonce_valid, consumed_count}, {1'b1, 1'b0, 4'b0000, 32'd0});
    end
    cyc(0, 0, 0, 4'b0000, '0, '0);
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_bad++; $display("FAIL empty_done got %b want 01", {busy, done});
    end
    cyc(1, 0, 0, 4'b0000, 32'd0, 32'd15);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL start_in_done got %b want 00", {busy, done});
    end
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 0, 4'b0000, 32'd40, 32'd90);
    cyc(0, 0, 0, 4'b1011, '0, '0);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, nonce_valid, consumed_count, nonce_out} !== '0) begin
      n_bad++; $display("FAIL async_reset got %h want 0", {busy, done, nonce_valid, consumed_count, nonce_out});
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

`ifdef MINER_SEQ_PAUSE_EN
  task automatic test_pause();
    cyc(1, 0, 0, 4'b0000, 32'd0, 32'd15);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 4'b1111, '0, '0);
      n_cmp++;
      if ({busy, nonce_valid, consumed_count, nonce_out} !== {1'b1, 4'b1111, 32'd0, 128'h00000003_00000002_00000001_00000000}) begin
        n_bad++; $display("FAIL pause_hold%0d got %h want %h", k, {busy, nonce_valid, consumed_count, nonce_out},
                          {1'b1, 4'b1111, 32'd0, 128'h00000003_00000002_00000001_00000000});
      end
    end
    cyc(0, 1, 1, 4'b0000, '0, '0);
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL pause_abort got %h want %h", obs_vec(), exp_vec());
    end
  endtask
`endif

  task automatic test_random();
    longint b, l;
    int     guard;
    bit     pz;
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 2) == 0) b = 64'hFFFF_FFFF - $urandom_range(0, 12);
      else b = $urandom_range(0, 50);
      if ($urandom_range(0, 5) == 0 && b > 0) l = b - 1 - $urandom_range(0, 3);
      else l = b + $urandom_range(0, 30);
      if (l > 64'hFFFF_FFFF) l = 64'hFFFF_FFFF;
      if (l < 0) l = 0;
      cyc(1, 0, 0, 4'b0000, b[31:0], l[31:0]);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL rnd%0d_start got %h want %h", r, obs_vec(), exp_vec());
      end
      guard = 0;
      while ((m_run || m_done) && guard < 300) begin
        pz = ($urandom_range(0, 4) == 0);
        cyc(1'($urandom), ($urandom_range(0, 60) == 0), pz, 4'($urandom), 32'($urandom), 32'($urandom));
        guard++;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
          n_bad++; $display("FAIL rnd%0d_cyc%0d got %h want %h", r, guard, obs_vec(), exp_vec());
        end
      end
      if (guard >= 300) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd%0d_timeout got busy=%b want run to finish", r, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_core();
    test_all_cores();
    test_top_of_range();
    test_abort_and_empty();
    test_async_reset();
`ifdef MINER_SEQ_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
